// File: rtl/seg7_reader_pkg.sv
// Shared constants for the seven-segment display reader: segment patterns,
// the invalid decode code and the control FSM state type.
package seg7_reader_pkg;

  // Segment patterns, bit6 = a ... bit0 = g, active-high.
  localparam logic [6:0] SEG_0 = 7'h7E;
  localparam logic [6:0] SEG_1 = 7'h30;
  localparam logic [6:0] SEG_2 = 7'h6D;
  localparam logic [6:0] SEG_3 = 7'h79;
  localparam logic [6:0] SEG_4 = 7'h33;
  localparam logic [6:0] SEG_5 = 7'h5B;
  localparam logic [6:0] SEG_6 = 7'h5F;
  localparam logic [6:0] SEG_7 = 7'h70;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h73;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h1F;
  localparam logic [6:0] SEG_C = 7'h4E;
  localparam logic [6:0] SEG_D = 7'h3D;
  localparam logic [6:0] SEG_E = 7'h4F;
  localparam logic [6:0] SEG_F = 7'h47;

  localparam logic [3:0] INVALID_CODE = 4'hF;

  typedef enum logic {
    ST_SCAN = 1'b0,
    ST_FULL = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/seg7_reader_pattern_decode.sv
// Combinational segment-pattern to digit-value decoder.
// Define SEG7_HEX_EN to also accept the A..F letter patterns.
module seg7_pattern_decode
  import seg7_reader_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] value,
  output logic       err
);

  always_comb begin
    value = INVALID_CODE;
    err   = 1'b1;
    case (pattern)
      SEG_0: begin value = 4'h0; err = 1'b0; end
      SEG_1: begin value = 4'h1; err = 1'b0; end
      SEG_2: begin value = 4'h2; err = 1'b0; end
      SEG_3: begin value = 4'h3; err = 1'b0; end
      SEG_4: begin value = 4'h4; err = 1'b0; end
      SEG_5: begin value = 4'h5; err = 1'b0; end
      SEG_6: begin value = 4'h6; err = 1'b0; end
      SEG_7: begin value = 4'h7; err = 1'b0; end
      SEG_8: begin value = 4'h8; err = 1'b0; end
      SEG_9: begin value = 4'h9; err = 1'b0; end
`ifdef SEG7_HEX_EN
      SEG_A: begin value = 4'hA; err = 1'b0; end
      SEG_B: begin value = 4'hB; err = 1'b0; end
      SEG_C: begin value = 4'hC; err = 1'b0; end
      SEG_D: begin value = 4'hD; err = 1'b0; end
      SEG_E: begin value = 4'hE; err = 1'b0; end
      SEG_F: begin value = 4'hF; err = 1'b0; end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/seg7_reader.sv
// Samples a multiplexed seven-segment display bus and rebuilds whole frames.
// Optional SEG7_HEX_EN (in the decoder) accepts hex letter patterns.
module seg7_reader
  import seg7_reader_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int NUM_DIGITS    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              sete_seg,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic                    out_ready,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    out_valid,
  output logic                    overrun,
  output ctrl_state_e             dbg_state
);

  // Handshake: a frame transfers on every rising edge where out_valid and
  // out_ready are both 1; out_valid never drops without that transfer.

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_SAT = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_CAP = CW'(STABLE_CYCLES - 1);

  logic [NUM_DIGITS-1:0]   an_prev;
  logic [6:0]              seg_prev;
  logic [CW-1:0]           cnt, cnt_next;
  logic                    an_onehot;
  logic                    capture;
  logic [3:0]              dec_val;
  logic                    dec_err;
  logic [4*NUM_DIGITS-1:0] stage_bcd;
  logic [NUM_DIGITS-1:0]   stage_err;
  logic [NUM_DIGITS-1:0]   captured;
  ctrl_state_e             state, state_next;
  logic                    frame_load, frame_drop;

  seg7_pattern_decode u_decode (
    .pattern (sete_seg),
    .value   (dec_val),
    .err     (dec_err)
  );

  assign an_onehot = $onehot(an);

  // cnt counts repeats of the current pattern, so the pattern has been held
  // cnt_next+1 cycles; capture fires once, when that reaches STABLE_CYCLES.
  always_comb begin
    if (!an_onehot || (an != an_prev) || (sete_seg != seg_prev)) begin
      cnt_next = '0;
    end else if (cnt == CNT_SAT) begin
      cnt_next = CNT_SAT;
    end else begin
      cnt_next = cnt + 1'b1;
    end
  end

  assign capture = an_onehot && (cnt_next == CNT_CAP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_prev  <= '0;
      seg_prev <= '0;
      cnt      <= '0;
    end else begin
      an_prev  <= an;
      seg_prev <= sete_seg;
      cnt      <= cnt_next;
    end
  end

  // an is one-hot whenever capture is set, so it doubles as the write mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_bcd <= '0;
      stage_err <= '0;
      captured  <= '0;
    end else begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (capture && an[k]) begin
          stage_bcd[4*k +: 4] <= dec_val;
          stage_err[k]        <= dec_err;
          captured[k]         <= 1'b1;
        end else if (state == ST_FULL) begin
          captured[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_SCAN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    frame_load = 1'b0;
    frame_drop = 1'b0;
    case (state)
      ST_SCAN: begin
        if (&captured) state_next = ST_FULL;
      end
      ST_FULL: begin
        state_next = ST_SCAN;
        if (!out_valid || out_ready) frame_load = 1'b1;
        else                         frame_drop = 1'b1;
      end
      default: state_next = ST_SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_out   <= '0;
      digit_err <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (frame_load) begin
        bcd_out   <= stage_bcd;
        digit_err <= stage_err;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (frame_drop) overrun <= 1'b1;
    end
  end

  assign dbg_state = state;

endmodule
